dcm_prog_ctrl: RTL and testbench
================================

// Module: dcm_prog_ctrl
// PURPOSE
// - Configuration sequencer for the programmable clock divider (dcm): owns its 3-bit prog select and update strobe.
// - Shares that single configuration resource between two requesters: 0 = local panel, 1 = remote/host.
// - Serialises requests, applies SET/INC/DEC with saturation, pulses update, then holds off new requests until the divider settles.
// PARAMETERS
// - SETTLE_CYCLES  128  clk cycles held in SETTLE after each update; >= 2x largest divider count (64)
// - RESET_PROG     1    prog value loaded on reset; matches the divider's reset timer
// - CNT_W          $clog2(SETTLE_CYCLES+1)  settle counter width, derived; do not override
// PORTS
// - clk        in   1  system clock
// - rst        in   1  synchronous, active-high reset
// - req        in   2  per-requester request; held high until matching ack
// - cmd0/cmd1  in   2  requester command: 00 SET, 01 INC, 10 DEC, 11 reserved
// - val0/val1  in   3  SET operand; ignored for INC/DEC
// - ack        out  2  one-cycle grant-complete pulse to the served requester
// - prog       out  3  registered divider select, drives dcm prog_in
// - update     out  1  one-cycle strobe, drives dcm update
// - busy       out  1  high in any state other than IDLE
// - sat        out  1  one-cycle pulse: INC at 7 or DEC at 0, value unchanged
// - err        out  1  one-cycle pulse: reserved cmd 11 served, value unchanged
// BEHAVIOUR
// - Reset: state=IDLE, prog=RESET_PROG, update=0, ack=0, busy=0, sat=0, err=0, settle count=0, rr pointer=0.
// - FSM states: IDLE -> UPD -> SETTLE -> IDLE.
// - IDLE, req!=0: arbitrate; grant g registered; prog loaded on same edge
//   - SET: prog <= val_g; INC: prog <= min(prog+1,7); DEC: prog <= max(prog-1,0).
//   - Saturation sets sat in the following UPD cycle.
//   - cmd 11: prog unchanged; err set in the following UPD cycle.
// - UPD, exactly 1 cycle:
//   - update=1, ack[g]=1, sat/err as determined; prog already stable since this cycle's start.
//   - Next state SETTLE, counter <= 1.
// - SETTLE:
//   - Counter increments each cycle; leave to IDLE when counter==SETTLE_CYCLES.
//   - Total lockout after the UPD cycle is SETTLE_CYCLES cycles.
// - Latency: req sampled in IDLE at cycle t -> prog new at t+1, update/ack at t+1, IDLE again at t+2+SETTLE_CYCLES.
// - Requests arriving in UPD/SETTLE are not lost, only deferred; req held past ack is a new request, served after SETTLE.
// - update always fires, even for no-change (cmd 11, saturated, SET to same value), so the divider phase is realigned.
// - Request dropped before ack: arbitration re-evaluated only in IDLE; a grant already taken completes.
// - rst mid-transaction: abandon immediately; no ack, no update; prog returns to RESET_PROG.
// - Width: all prog arithmetic in 3 bits with explicit saturation, never wrap.
// CONFIGURATION
// - DCM_CTRL_RR_EN defined:
//   - Round-robin arbitration; 1-bit pointer names the preferred requester.
//   - After a grant, pointer <= ~g.
//   - Simultaneous requests alternate 0,1,0,...
// - DCM_CTRL_RR_EN undefined:
//   - Fixed priority, requester 0 always wins a tie; no pointer register.
// STRUCTURE
// - Shared package dcm_pkg:
//   - cmd encodings CMD_SET/CMD_INC/CMD_DEC/CMD_RSV.
//   - FSM state typedef (IDLE, UPD, SETTLE).
//   - PROG_W=3, PROG_MAX=7.
// - One sub-module: dcm_req_arb.
//   - 2-way arbiter, inputs req/pointer, output one-hot grant; holds the DCM_CTRL_RR_EN variation.
// - FSM, prog register, settle counter in top.
// TESTING
// - Reset release, no req: prog=1, busy=0, update never pulses across 500 cycles.
// - req0 SET val0=5 at t: prog=5 at t+1, update=ack[0]=1 only at t+1, busy drops at t+2+SETTLE_CYCLES.
// - From prog=7, req1 INC: prog stays 7, sat=1 with update; from prog=0, DEC: prog 0, sat=1.
// - req0/req1 held together, SET 2 vs SET 6, each held until its own ack:
//   - RR: acks alternate 0,1,0; fixed: req0 served first, req1 served only after req0 drops.
// - cmd 11 from req0: err=1, ack[0]=1, update=1, prog unchanged.
// - rst asserted in SETTLE after SET 4: next cycle prog=1, ack=0, busy=0; pending req served after rst drops.

Source files
------------

// File: rtl/dcm_prog_ctrl_pkg.sv
// Shared types for the dcm configuration sequencer: command encodings,
// FSM states, prog width/limits and the SET/INC/DEC update function.
package dcm_pkg;

    localparam int          PROG_W   = 3;
    localparam logic [2:0]  PROG_MAX = 3'd7;

    typedef enum logic [1:0] {
        CMD_SET = 2'b00,
        CMD_INC = 2'b01,
        CMD_DEC = 2'b10,
        CMD_RSV = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        UPD    = 2'b01,
        SETTLE = 2'b10
    } state_e;

    typedef struct packed {
        logic [PROG_W-1:0] prog;
        logic              sat;
        logic              err;
    } prog_res_t;

    // Next prog value for a served command. Arithmetic stays in PROG_W bits
    // and saturates at both ends instead of wrapping.
    function automatic prog_res_t apply_cmd(cmd_e cmd, logic [PROG_W-1:0] cur,
                                            logic [PROG_W-1:0] val);
        prog_res_t r;
        r.prog = cur;
        r.sat  = 1'b0;
        r.err  = 1'b0;
        case (cmd)
            CMD_SET: r.prog = val;
            CMD_INC: begin
                if (cur == PROG_MAX) r.sat  = 1'b1;
                else                 r.prog = cur + PROG_W'(1);
            end
            CMD_DEC: begin
                if (cur == '0) r.sat  = 1'b1;
                else           r.prog = cur - PROG_W'(1);
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// Requester/controller bus for the dcm configuration sequencer.
// master = requester side (panel/host), slave = the controller.
interface dcm_prog_ctrl_if;
    import dcm_pkg::*;

    logic [1:0]        req;
    logic [1:0]        cmd0;
    logic [1:0]        cmd1;
    logic [PROG_W-1:0] val0;
    logic [PROG_W-1:0] val1;
    logic [1:0]        ack;
    logic [PROG_W-1:0] prog;
    logic              update;
    logic              busy;
    logic              sat;
    logic              err;

    modport master (
        output req, cmd0, cmd1, val0, val1,
        input  ack, prog, update, busy, sat, err
    );

    modport slave (
        input  req, cmd0, cmd1, val0, val1,
        output ack, prog, update, busy, sat, err
    );

endinterface

// File: rtl/dcm_prog_ctrl_req_arb.sv
// Two-way request arbiter, one-hot grant.
// With DCM_CTRL_RR_EN defined, a tie goes to the requester named by ptr;
// otherwise requester 0 always wins a tie and there is no ptr input.
module dcm_req_arb (
    input  logic [1:0] req,
`ifdef DCM_CTRL_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] grant
);

    // Single requests pass straight through; only a tie needs a decision.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
`ifdef DCM_CTRL_RR_EN
            grant = ptr ? 2'b10 : 2'b01;
`else
            grant = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Configuration sequencer for the programmable clock divider. Serialises
// panel (0) and host (1) requests, applies SET/INC/DEC with saturation,
// strobes update, then locks out new requests for SETTLE_CYCLES cycles.
// Optional feature macro: DCM_CTRL_RR_EN (round-robin tie-breaking).
module dcm_prog_ctrl
    import dcm_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 128,
    parameter logic [2:0] RESET_PROG    = 3'd1
) (
    input  logic           clk,
    input  logic           rst,
    dcm_prog_ctrl_if.slave bus
);

    // Settle counter must reach SETTLE_CYCLES; width follows from it.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_e            state;
    logic [PROG_W-1:0] prog_q;
    logic              update_q;
    logic [1:0]        ack_q;
    logic              busy_q;
    logic              sat_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        grant;
    logic              sel;
    cmd_e              cmd_g;
    logic [PROG_W-1:0] val_g;
    prog_res_t         res;

`ifdef DCM_CTRL_RR_EN
    logic              rr_ptr;

    dcm_req_arb u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (grant)
    );
`else
    dcm_req_arb u_arb (
        .req   (bus.req),
        .grant (grant)
    );
`endif

    // Route the granted requester's command to the update function.
    assign sel   = grant[1];
    assign cmd_g = cmd_e'(sel ? bus.cmd1 : bus.cmd0);
    assign val_g = sel ? bus.val1 : bus.val0;
    assign res   = apply_cmd(cmd_g, prog_q, val_g);

    assign bus.prog   = prog_q;
    assign bus.update = update_q;
    assign bus.ack    = ack_q;
    assign bus.busy   = busy_q;
    assign bus.sat    = sat_q;
    assign bus.err    = err_q;

    // Sequencer FSM: the grant edge loads prog and arms the one-cycle UPD
    // outputs, so update/ack/sat/err are all registered and aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prog_q   <= RESET_PROG;
            update_q <= 1'b0;
            ack_q    <= 2'b00;
            busy_q   <= 1'b0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
`ifdef DCM_CTRL_RR_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state    <= UPD;
                        prog_q   <= res.prog;
                        sat_q    <= res.sat;
                        err_q    <= res.err;
                        update_q <= 1'b1;
                        ack_q    <= grant;
                        busy_q   <= 1'b1;
`ifdef DCM_CTRL_RR_EN
                        rr_ptr   <= ~grant[1];
`endif
                    end
                end
                UPD: begin
                    update_q <= 1'b0;
                    ack_q    <= 2'b00;
                    sat_q    <= 1'b0;
                    err_q    <= 1'b0;
                    cnt      <= CNT_W'(1);
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl: reset, SET latency, saturation,
// reserved command, contention, and reset in the middle of SETTLE.
module tb_dcm_prog_ctrl;
    import dcm_pkg::*;

    localparam int SC = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dcm_prog_ctrl_if bus();

    dcm_prog_ctrl #(.SETTLE_CYCLES(SC), .RESET_PROG(3'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_update(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.update === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_update: update=%b after 400 cycles, want 1", bus.update);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after 400 cycles, want 0", bus.busy);
        end
    endtask

    task automatic serve(input int r, input logic [1:0] c, input logic [2:0] v,
                         output logic [2:0] p, output logic s, output logic e,
                         output logic [1:0] a);
        bit ok;
        if (r == 0) begin bus.cmd0 = c; bus.val0 = v; end
        else        begin bus.cmd1 = c; bus.val1 = v; end
        bus.req[r] = 1'b1;
        wait_update(ok);
        p = bus.prog; s = bus.sat; e = bus.err; a = bus.ack;
        bus.req[r] = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        bus.req = 2'b00; bus.cmd0 = 2'b00; bus.cmd1 = 2'b00;
        bus.val0 = 3'd0; bus.val1 = 3'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.prog !== 3'd1) begin errors++; $display("FAIL reset_prog: got %0d want 1", bus.prog); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
        checks++; if ({bus.update, bus.sat, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {bus.update, bus.sat, bus.err}); end
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.update !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
    endtask

    task automatic test_set();
        int bad;
        bus.cmd0 = CMD_SET; bus.val0 = 3'd5; bus.req = 2'b01;
        tick();
        checks++; if (bus.prog !== 3'd5) begin errors++; $display("FAIL set_prog: got %0d want 5", bus.prog); end
        checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL set_update: got %b want 1", bus.update); end
        checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL set_ack: got %b want 01", bus.ack); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL set_busy: got %b want 1", bus.busy); end
        bus.req = 2'b00;
        bad = 0;
        for (int i = 0; i < SC; i++) begin
            tick();
            if (bus.update !== 1'b0 || bus.ack !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL set_single_pulse: %0d extra strobes, want 0", bad); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL settle_last: busy=%b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL settle_exit: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_sat();
        logic [2:0] p; logic s, e; logic [1:0] a;
        serve(0, CMD_SET, 3'd7, p, s, e, a);
        serve(1, CMD_INC, 3'd0, p, s, e, a);
        checks++; if ({p, s, a} !== {3'd7, 1'b1, 2'b10}) begin errors++; $display("FAIL inc_sat: prog=%0d sat=%b ack=%b want 7 1 10", p, s, a); end
        serve(1, CMD_DEC, 3'd0, p, s, e, a);
        checks++; if ({p, s} !== {3'd6, 1'b0}) begin errors++; $display("FAIL dec_norm: prog=%0d sat=%b want 6 0", p, s); end
        serve(0, CMD_SET, 3'd0, p, s, e, a);
        serve(0, CMD_DEC, 3'd5, p, s, e, a);
        checks++; if ({p, s, a} !== {3'd0, 1'b1, 2'b01}) begin errors++; $display("FAIL dec_sat: prog=%0d sat=%b ack=%b want 0 1 01", p, s, a); end
        serve(0, CMD_INC, 3'd0, p, s, e, a);
        checks++; if ({p, s} !== {3'd1, 1'b0}) begin errors++; $display("FAIL inc_norm: prog=%0d sat=%b want 1 0", p, s); end
    endtask

    task automatic test_err();
        logic [2:0] p; logic s, e; logic [1:0] a;
        serve(0, CMD_SET, 3'd3, p, s, e, a);
        serve(0, CMD_RSV, 3'd6, p, s, e, a);
        checks++; if ({p, e, s, a} !== {3'd3, 1'b1, 1'b0, 2'b01}) begin errors++; $display("FAIL rsv_cmd: prog=%0d err=%b sat=%b ack=%b want 3 1 0 01", p, e, s, a); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [3];
        bit ok;
`ifdef DCM_CTRL_RR_EN
        exp = '{2'b01, 2'b10, 2'b01};
`else
        exp = '{2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        bus.cmd0 = CMD_SET; bus.val0 = 3'd2;
        bus.cmd1 = CMD_SET; bus.val1 = 3'd6;
        bus.req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_update(ok);
            checks++; if (bus.ack !== exp[k]) begin errors++; $display("FAIL b2b_ack%0d: got %b want %b", k, bus.ack, exp[k]); end
            checks++; if (bus.prog !== ((exp[k] == 2'b01) ? 3'd2 : 3'd6)) begin errors++; $display("FAIL b2b_prog%0d: got %0d", k, bus.prog); end
        end
        bus.req[0] = 1'b0;
        wait_update(ok);
        checks++; if ({bus.ack, bus.prog} !== {2'b10, 3'd6}) begin errors++; $display("FAIL b2b_req1: ack=%b prog=%0d want 10 6", bus.ack, bus.prog); end
        bus.req = 2'b00;
        wait_idle();
    endtask

    task automatic test_rst_mid();
        bit ok;
        bus.cmd0 = CMD_SET; bus.val0 = 3'd4; bus.req = 2'b01;
        wait_update(ok);
        checks++; if (bus.prog !== 3'd4) begin errors++; $display("FAIL mid_set: prog=%0d want 4", bus.prog); end
        bus.req = 2'b10; bus.cmd1 = CMD_INC;
        repeat (10) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_settle: busy=%b want 1", bus.busy); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.prog, bus.ack, bus.busy, bus.update} !== {3'd1, 2'b00, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_rst: prog=%0d ack=%b busy=%b upd=%b want 1 00 0 0", bus.prog, bus.ack, bus.busy, bus.update); end
        rst = 1'b0;
        tick();
        checks++; if ({bus.update, bus.ack, bus.prog} !== {1'b1, 2'b10, 3'd2}) begin errors++; $display("FAIL mid_pending: upd=%b ack=%b prog=%0d want 1 10 2", bus.update, bus.ack, bus.prog); end
        bus.req = 2'b00;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_set();
        test_sat();
        test_err();
        test_back_to_back();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
